parallel_hypervisor_cpu_mult_pipe: RTL and testbench

- Parametrised, handshaked pipelined multiplier for the CPU M-stage.
- Successor to the fixed three-partial-product 16x16 cell: arbitrary even DATA_W, configurable pipeline depth, and all four partial products.
- Produces the full 2*DATA_W product and returns the low or high word per op (mul, mulxuu, mulxsu, mulxss), with operand signedness handled internally.
- Adds valid/ready flow control with backpressure, a flush input, and a destination tag carried alongside each operation.

---
 rtl/parallel_hypervisor_cpu_mult_pipe.sv | 143 ++++++++++++++
 tb/tb_parallel_hypervisor_cpu_mult_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/parallel_hypervisor_cpu_mult_pipe.sv
// Handshaked pipelined DATA_W x DATA_W multiplier for the M-stage.
// Four registered partial products, a configurable carry pipeline and a summing output register.
module parallel_hypervisor_cpu_mult_pipe #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              E_valid,
  output logic              E_ready,
  input  logic [1:0]        E_op,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic [TAG_W-1:0]  E_tag,
  input  logic              M_flush,
  output logic              M_valid,
  input  logic              M_ready,
  output logic [DATA_W-1:0] M_result,
  output logic [TAG_W-1:0]  M_tag,
  output logic              M_busy
);

  localparam int unsigned H  = DATA_W / 2;
  localparam int unsigned FW = 2 * DATA_W;
  localparam int unsigned S  = PIPE_STAGES;

  logic                advance_c;
  logic                accept_c;

  logic                a_sgn_c;
  logic                b_sgn_c;
  logic signed [H:0]   a_lo_c;
  logic signed [H:0]   a_hi_c;
  logic signed [H:0]   b_lo_c;
  logic signed [H:0]   b_hi_c;
  logic [2*H-1:0]      pp_ll_c;
  logic signed [2*H:0] pp_lh_c;
  logic signed [2*H:0] pp_hl_c;
  logic signed [2*H+1:0] pp_hh_c;

  logic [S-1:0]          vld_q, vld_d;
  logic [2*H-1:0]        ll_q  [S];
  logic signed [2*H:0]   lh_q  [S];
  logic signed [2*H:0]   hl_q  [S];
  logic signed [2*H+1:0] hh_q  [S];
  logic                  hi_q  [S];
  logic [TAG_W-1:0]      tag_q [S];

  logic [FW-1:0]       full_c;
  logic                m_vld_q, m_vld_d;
  logic [DATA_W-1:0]   m_res_q, m_res_d;
  logic [TAG_W-1:0]    m_tag_q;

  // A full output register that is not being consumed freezes the whole pipe.
  assign advance_c = !(m_vld_q && !M_ready);
  assign E_ready   = advance_c && !M_flush;
  assign accept_c  = E_valid && E_ready;

  assign M_valid  = m_vld_q;
  assign M_result = m_res_q;
  assign M_tag    = m_tag_q;
  assign M_busy   = (|vld_q) || m_vld_q;

  // Upper halves carry one extra bit so signed and unsigned ops share the same multipliers.
  always_comb begin
    a_sgn_c = E_op[1];
    b_sgn_c = (E_op == 2'b11);
    a_lo_c  = {1'b0, E_src1[H-1:0]};
    b_lo_c  = {1'b0, E_src2[H-1:0]};
    a_hi_c  = {a_sgn_c & E_src1[DATA_W-1], E_src1[DATA_W-1:H]};
    b_hi_c  = {b_sgn_c & E_src2[DATA_W-1], E_src2[DATA_W-1:H]};
    pp_ll_c = (2*H)'(E_src1[H-1:0]) * (2*H)'(E_src2[H-1:0]);
    pp_lh_c = (2*H+1)'(a_lo_c) * (2*H+1)'(b_hi_c);
    pp_hl_c = (2*H+1)'(a_hi_c) * (2*H+1)'(b_lo_c);
    pp_hh_c = (2*H+2)'(a_hi_c) * (2*H+2)'(b_hi_c);
  end

  always_comb begin
    full_c = (FW'(hh_q[S-1]) << DATA_W)
           + ((FW'(lh_q[S-1]) + FW'(hl_q[S-1])) << H)
           + FW'(ll_q[S-1]);
    m_res_d = hi_q[S-1] ? full_c[FW-1:DATA_W] : full_c[DATA_W-1:0];
  end

  // Valid-bit next state: flush wins over stall, bubbles advance like ops.
  always_comb begin
    vld_d   = vld_q;
    m_vld_d = m_vld_q;
    if (M_flush) begin
      vld_d   = '0;
      m_vld_d = 1'b0;
    end else if (advance_c) begin
      vld_d[0] = accept_c;
      for (int i = 1; i < int'(S); i++) begin
        vld_d[i] = vld_q[i-1];
      end
      m_vld_d = vld_q[S-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      m_vld_q <= 1'b0;
      m_res_q <= '0;
      m_tag_q <= '0;
      for (int i = 0; i < int'(S); i++) begin
        ll_q[i]  <= '0;
        lh_q[i]  <= '0;
        hl_q[i]  <= '0;
        hh_q[i]  <= '0;
        hi_q[i]  <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      m_vld_q <= m_vld_d;
      if (advance_c) begin
        ll_q[0]  <= pp_ll_c;
        lh_q[0]  <= pp_lh_c;
        hl_q[0]  <= pp_hl_c;
        hh_q[0]  <= pp_hh_c;
        hi_q[0]  <= (E_op != 2'b00);
        tag_q[0] <= E_tag;
        for (int i = 1; i < int'(S); i++) begin
          ll_q[i]  <= ll_q[i-1];
          lh_q[i]  <= lh_q[i-1];
          hl_q[i]  <= hl_q[i-1];
          hh_q[i]  <= hh_q[i-1];
          hi_q[i]  <= hi_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
        // Output word only reloads for a real op so idle outputs stay quiet.
        if (vld_q[S-1] && !M_flush) begin
          m_res_q <= m_res_d;
          m_tag_q <= tag_q[S-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_parallel_hypervisor_cpu_mult_pipe.sv
// Directed bench for parallel_hypervisor_cpu_mult_pipe at DATA_W=32, PIPE_STAGES=2.
module tb_parallel_hypervisor_cpu_mult_pipe;

  logic        clk;
  logic        reset_n;
  logic        E_valid;
  logic        E_ready;
  logic [1:0]  E_op;
  logic [31:0] E_src1;
  logic [31:0] E_src2;
  logic [4:0]  E_tag;
  logic        M_flush;
  logic        M_valid;
  logic        M_ready;
  logic [31:0] M_result;
  logic [4:0]  M_tag;
  logic        M_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  parallel_hypervisor_cpu_mult_pipe #(
    .DATA_W(32), .PIPE_STAGES(2), .TAG_W(5)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .E_valid(E_valid), .E_ready(E_ready), .E_op(E_op),
    .E_src1(E_src1), .E_src2(E_src2), .E_tag(E_tag),
    .M_flush(M_flush),
    .M_valid(M_valid), .M_ready(M_ready), .M_result(M_result),
    .M_tag(M_tag), .M_busy(M_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, then measure latency and check the returned word and tag.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    int lat;
    E_valid = 1'b1; E_op = op; E_src1 = a; E_src2 = b; E_tag = tag;
    #1;
    check({name, "_eready"}, 64'(E_ready), 64'd1);
    @(negedge clk);
    E_valid = 1'b0;
    lat = 1;
    while (!M_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_result"}, 64'(M_result), 64'(exp));
    check({name, "_tag"}, 64'(M_tag), 64'(tag));
    @(negedge clk);
  endtask

  initial begin
    int nsent, ngot, stall_left, extra;
    bit seen, saw;
    logic [31:0] held;
    logic [4:0]  got_tag [4];
    logic [31:0] got_res [4];

    reset_n = 1'b0; E_valid = 1'b0; E_op = 2'b00; E_src1 = '0; E_src2 = '0;
    E_tag = '0; M_flush = 1'b0; M_ready = 1'b1;
    #1;
    check("rst_mvalid", 64'(M_valid), 64'd0);
    check("rst_busy", 64'(M_busy), 64'd0);
    check("rst_result", 64'(M_result), 64'd0);
    check("rst_tag", 64'(M_tag), 64'd0);
    check("rst_eready", 64'(E_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("lat_mul",   2'b00, 32'h0001_0000, 32'h0001_0000, 5'd3, 32'h0000_0000);
    run_op("lat_mulxuu", 2'b01, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'h0000_0001);
    run_op("m1_uu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
    run_op("m1_ss", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000);
    run_op("m1_su", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF);
    run_op("m1_lo", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'h0000_0001);
    run_op("min_ss", 2'b11, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000);
    run_op("min_uu", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000);
    run_op("mix_lo", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 32'h242D_2080);
    run_op("mix_uu", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 32'h0B00_EA4E);
    run_op("su_pos", 2'b10, 32'h8000_0000, 32'h0000_0002, 5'd13, 32'hFFFF_FFFF);

    // Backpressure: four back-to-back ops, consumer stalls three cycles at the first result.
    nsent = 0; ngot = 0; stall_left = 0; seen = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && ngot < 4; cyc++) begin
      if (nsent < 4) begin
        E_valid = 1'b1; E_op = 2'b00; E_src1 = 32'(nsent + 1);
        E_src2 = 32'h100; E_tag = 5'(nsent + 1);
      end else begin
        E_valid = 1'b0;
      end
      if (M_valid && !seen) begin
        seen = 1'b1; stall_left = 3; held = M_result;
      end
      M_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) check("bp_eready_low", 64'(E_ready), 64'd0);
      if (stall_left > 0 && stall_left < 3) begin
        check("bp_result_hold", 64'(M_result), 64'(held));
        check("bp_tag_hold", 64'(M_tag), 64'd1);
      end
      if (E_valid && E_ready) nsent++;
      if (M_valid && M_ready) begin
        if (ngot < 4) begin
          got_tag[ngot] = M_tag; got_res[ngot] = M_result;
        end
        ngot++;
      end
      if (stall_left > 0) stall_left--;
      @(negedge clk);
    end
    E_valid = 1'b0; M_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (M_valid) extra++;
      @(negedge clk);
    end
    check("bp_sent", 64'(nsent), 64'd4);
    check("bp_got", 64'(ngot), 64'd4);
    check("bp_no_dup", 64'(extra), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < ngot) begin
        check("bp_order_tag", 64'(got_tag[i]), 64'(i + 1));
        check("bp_order_res", 64'(got_res[i]), 64'((i + 1) * 256));
      end
    end

    // Flush with two ops in flight and a third offered in the flush cycle.
    E_valid = 1'b1; E_op = 2'b00; E_src1 = 32'd5; E_src2 = 32'd6; E_tag = 5'd20;
    @(negedge clk);
    E_tag = 5'd21;
    @(negedge clk);
    E_tag = 5'd22; M_flush = 1'b1;
    #1;
    check("fl_eready", 64'(E_ready), 64'd0);
    @(negedge clk);
    M_flush = 1'b0; E_valid = 1'b0;
    check("fl_mvalid", 64'(M_valid), 64'd0);
    check("fl_busy", 64'(M_busy), 64'd0);
    saw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (M_valid) saw = 1'b1;
      @(negedge clk);
    end
    check("fl_no_result", 64'(saw), 64'd0);
    run_op("fl_after", 2'b00, 32'd7, 32'd9, 5'd23, 32'd63);

    // Asynchronous reset with three ops in flight.
    E_valid = 1'b1; E_op = 2'b01; E_src1 = 32'h1234_5678; E_src2 = 32'h9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      E_tag = 5'(24 + i);
      @(negedge clk);
    end
    E_valid = 1'b0;
    check("ar_inflight_valid", 64'(M_valid), 64'd1);
    check("ar_inflight_result", 64'(M_result), 64'h0B00_EA4E);
    #2 reset_n = 1'b0;
    #1;
    check("ar_mvalid", 64'(M_valid), 64'd0);
    check("ar_busy", 64'(M_busy), 64'd0);
    check("ar_result", 64'(M_result), 64'd0);
    check("ar_tag", 64'(M_tag), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ar_eready", 64'(E_ready), 64'd1);
    @(negedge clk);
    run_op("ar_after", 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 5'd30, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
